// File: rtl/disp_pkg.sv
// Shared types and constants for the
// seven-segment display scanner.
package disp_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_BLANK = 4'hF;
  typedef logic [DIGIT_W-1:0] bcd_t;
endpackage

// File: rtl/disp_refresh_tick.sv
// Free-running prescaler that emits one
// single-cycle tick every DIV enabled cycles.
module disp_refresh_tick #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = enable && (cnt_q == CW'(DIV - 1));
    cnt_d = cnt_q;
    if (tick) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed scanner for a common-anode
// seven-segment display with zero blanking.
module bcd_display_scanner
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  localparam int SEL_W = $clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  input  logic                    enable,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    dp_n,
  output logic [SEL_W-1:0]        digit_sel
);
  localparam int SW = DIGIT_W * NUM_DIGITS;

  logic [SW-1:0]         shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] sdp_q, sdp_d;
  logic [SEL_W-1:0]      idx_q, idx_d;
  logic                  dead_q, dead_d;
  bcd_t                  bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  dpn_q, dpn_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [NUM_DIGITS-1:0] blank;
  logic                  zeros;
  logic                  tick;

  disp_refresh_tick #(
    .DIV (REFRESH_DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .tick   (tick)
  );

  // Walk down from the MSD; a digit is blank
  // while everything above and itself is zero.
  always_comb begin
    blank = '0;
    zeros = blank_lz;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zeros = zeros &&
        (shadow_q[i*DIGIT_W +: DIGIT_W] == '0);
      blank[i] = zeros;
    end
  end

  always_comb begin
    shadow_d = load ? digits_in : shadow_q;
    sdp_d    = load ? dp_in : sdp_q;
    idx_d    = idx_q;
    if (tick) begin
      idx_d = (idx_q == SEL_W'(NUM_DIGITS - 1))
            ? '0 : idx_q + 1'b1;
    end
    dead_d = tick;
    an_d   = '1;
    bcd_d  = BCD_BLANK;
    dpn_d  = 1'b1;
    sel_d  = idx_q;
    if (enable && !dead_q && !blank[idx_q]) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      bcd_d = shadow_q[idx_q*DIGIT_W +: DIGIT_W];
      dpn_d = ~sdp_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      sdp_q    <= '0;
      idx_q    <= '0;
      dead_q   <= 1'b0;
      bcd_q    <= BCD_BLANK;
      an_q     <= '1;
      dpn_q    <= 1'b1;
      sel_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      sdp_q    <= sdp_d;
      idx_q    <= idx_d;
      dead_q   <= dead_d;
      bcd_q    <= bcd_d;
      an_q     <= an_d;
      dpn_q    <= dpn_d;
      sel_q    <= sel_d;
    end
  end

  assign bcd_out   = bcd_q;
  assign an_n      = an_q;
  assign dp_n      = dpn_q;
  assign digit_sel = sel_q;
endmodule
